// File: rtl/axi_lite_regif_if.sv
// Bus bundle for axi_lite_regif: AXI-Lite write/read channels plus the user register port.
// The slave modport is the register interface block; master is the AXI host and register-file side.
interface axi_lite_regif_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
    logic                    i_awvalid;
    logic                    o_awready;
    logic [ADDR_WIDTH-1:0]   i_awaddr;
    logic                    i_wvalid;
    logic                    o_wready;
    logic [DATA_WIDTH-1:0]   i_wdata;
    logic [STROBE_WIDTH-1:0] i_wstrb;
    logic                    o_bvalid;
    logic                    i_bready;
    logic [1:0]              o_bresp;

    logic                    i_arvalid;
    logic                    o_arready;
    logic [ADDR_WIDTH-1:0]   i_araddr;
    logic                    o_rvalid;
    logic                    i_rready;
    logic [DATA_WIDTH-1:0]   o_rdata;
    logic [1:0]              o_rresp;

    logic [ADDR_WIDTH-1:0]   o_reg_address;
    logic                    o_reg_wr_req;
    logic [DATA_WIDTH-1:0]   o_reg_wr_data;
    logic [STROBE_WIDTH-1:0] o_reg_wr_strb;
    logic                    i_reg_wr_ack_stb;
    logic                    o_reg_rd_req;
    logic                    i_reg_rd_ack_stb;
    logic [DATA_WIDTH-1:0]   i_reg_rd_data;
    logic                    i_reg_invalid_addr;

    modport slave (
        input  i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
        input  i_arvalid, i_araddr, i_rready,
        input  i_reg_wr_ack_stb, i_reg_rd_ack_stb, i_reg_rd_data, i_reg_invalid_addr,
        output o_awready, o_wready, o_bvalid, o_bresp,
        output o_arready, o_rvalid, o_rdata, o_rresp,
        output o_reg_address, o_reg_wr_req, o_reg_wr_data, o_reg_wr_strb, o_reg_rd_req
    );

    modport master (
        output i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
        output i_arvalid, i_araddr, i_rready,
        output i_reg_wr_ack_stb, i_reg_rd_ack_stb, i_reg_rd_data, i_reg_invalid_addr,
        input  o_awready, o_wready, o_bvalid, o_bresp,
        input  o_arready, o_rvalid, o_rdata, o_rresp,
        input  o_reg_address, o_reg_wr_req, o_reg_wr_data, o_reg_wr_strb, o_reg_rd_req
    );
endinterface

// File: rtl/axi_lite_regif.sv
// AXI-Lite slave that forwards one transaction at a time to a strobe-acknowledged user register port,
// with fair read/write arbitration and an optional user-ack timeout.
module axi_lite_regif #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_lite_regif_if.slave bus
);
    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_USER,
        WR_RESP,
        RD_USER,
        RD_RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    aw_got;
    logic                    w_got;
    logic                    prio_read;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STROBE_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              bresp;
    logic [1:0]              rresp;

    logic rd_grant;
    logic awready;
    logic wready;
    logic arready;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_ack;
    logic rd_ack;
    logic timeout;

    // Readies are forced low during reset so a host cannot handshake into a block that is being cleared.
    always_comb begin
        rd_grant = bus.i_arvalid && (!(bus.i_awvalid || bus.i_wvalid) || prio_read);
        arready  = rst_n && (state == IDLE) && rd_grant;
        awready  = rst_n && (((state == IDLE) && !rd_grant) || ((state == WR_COLLECT) && !aw_got));
        wready   = rst_n && (((state == IDLE) && !rd_grant) || ((state == WR_COLLECT) && !w_got));
        aw_hs    = bus.i_awvalid && awready;
        w_hs     = bus.i_wvalid && wready;
        ar_hs    = bus.i_arvalid && arready;
        wr_ack   = (state == WR_USER) && bus.i_reg_wr_ack_stb;
        rd_ack   = (state == RD_USER) && bus.i_reg_rd_ack_stb;
        timeout  = (TIMEOUT > 0) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_next = RD_USER;
                end else if (aw_hs && w_hs) begin
                    state_next = WR_USER;
                end else if (aw_hs || w_hs) begin
                    state_next = WR_COLLECT;
                end
            end
            WR_COLLECT: begin
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    state_next = WR_USER;
                end
            end
            WR_USER: begin
                if (wr_ack || timeout) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.i_bready) begin
                    state_next = IDLE;
                end
            end
            RD_USER: begin
                if (rd_ack || timeout) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.i_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: beat capture, ack-wait counter, response registers and arbitration priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            prio_read <= 1'b0;
            cnt       <= '0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rdata     <= '0;
            bresp     <= RESP_OKAY;
            rresp     <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                addr <= bus.i_araddr;
            end
            if (aw_hs) begin
                addr <= bus.i_awaddr;
            end
            if (w_hs) begin
                wdata <= bus.i_wdata;
                wstrb <= bus.i_wstrb;
            end

            if (state_next == WR_COLLECT) begin
                aw_got <= aw_got || aw_hs;
                w_got  <= w_got || w_hs;
            end else begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end

            if (((state == WR_USER) || (state == RD_USER)) && (state_next == state)) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end else begin
                cnt <= '0;
            end

            // An ack in the same cycle as the timeout wins, so it is tested first.
            if (wr_ack) begin
                bresp <= bus.i_reg_invalid_addr ? RESP_DECERR : RESP_OKAY;
            end else if ((state == WR_USER) && timeout) begin
                bresp <= RESP_SLVERR;
            end

            if (rd_ack) begin
                rdata <= bus.i_reg_rd_data;
                rresp <= bus.i_reg_invalid_addr ? RESP_DECERR : RESP_OKAY;
            end else if ((state == RD_USER) && timeout) begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end

            if ((state == WR_RESP) && bus.i_bready) begin
                prio_read <= 1'b1;
            end else if ((state == RD_RESP) && bus.i_rready) begin
                prio_read <= 1'b0;
            end
        end
    end

    assign bus.o_awready     = awready;
    assign bus.o_wready      = wready;
    assign bus.o_arready     = arready;
    assign bus.o_bvalid      = (state == WR_RESP);
    assign bus.o_bresp       = bresp;
    assign bus.o_rvalid      = (state == RD_RESP);
    assign bus.o_rdata       = rdata;
    assign bus.o_rresp       = rresp;
    assign bus.o_reg_address = addr;
    assign bus.o_reg_wr_req  = (state == WR_USER);
    assign bus.o_reg_wr_data = wdata;
    assign bus.o_reg_wr_strb = wstrb;
    assign bus.o_reg_rd_req  = (state == RD_USER);
endmodule

// File: tb/tb_axi_lite_regif.sv
// Randomized self-checking bench for axi_lite_regif; a transaction-level model predicts grants,
// request durations, responses and read data from ack timing, invalid-address flags and priority history.
module tb_axi_lite_regif;
    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int STROBE_WIDTH = 4;
    localparam int TIMEOUT      = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    bit          model_prio_read;
    logic [31:0] model_rdata;

    axi_lite_regif_if #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .STROBE_WIDTH(STROBE_WIDTH)
    ) bus ();

    axi_lite_regif #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .STROBE_WIDTH(STROBE_WIDTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_awvalid          = 1'b0;
        bus.i_awaddr           = '0;
        bus.i_wvalid           = 1'b0;
        bus.i_wdata            = '0;
        bus.i_wstrb            = '0;
        bus.i_bready           = 1'b0;
        bus.i_arvalid          = 1'b0;
        bus.i_araddr           = '0;
        bus.i_rready           = 1'b0;
        bus.i_reg_wr_ack_stb   = 1'b0;
        bus.i_reg_rd_ack_stb   = 1'b0;
        bus.i_reg_rd_data      = '0;
        bus.i_reg_invalid_addr = 1'b0;
    endtask

    function automatic logic [1:0] expected_resp(input int ack_at, input bit inv);
        if (ack_at > TIMEOUT) return 2'b10;
        return inv ? 2'b11 : 2'b00;
    endfunction

    function automatic int expected_req_cycles(input int ack_at);
        return (ack_at > TIMEOUT) ? TIMEOUT : ack_at;
    endfunction

    // ack_at is the request cycle (1-based) on which the user side strobes its ack.
    task automatic write_txn(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int ack_at, input bit inv,
                             input int b_dly);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        int n = 0;
        int k = 0;
        logic [1:0] exp_resp = expected_resp(ack_at, inv);
        bus.i_arvalid = 1'b0;
        bus.i_awaddr  = a;
        bus.i_wdata   = d;
        bus.i_wstrb   = s;
        while (!(aw_done && w_done) && n < 40) begin
            bus.i_awvalid = !aw_done && (n >= aw_dly);
            bus.i_wvalid  = !w_done && (n >= w_dly);
            #1;
            checkOutput("wr_req_early", 64'(bus.o_reg_wr_req), 64'(0));
            if (bus.i_awvalid && bus.o_awready) aw_done = 1'b1;
            if (bus.i_wvalid && bus.o_wready) w_done = 1'b1;
            tick();
            n++;
        end
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            checkOutput("wr_handshake", 64'(0), 64'(1));
            return;
        end
        checkOutput("wr_req", 64'(bus.o_reg_wr_req), 64'(1));
        checkOutput("wr_addr", 64'(bus.o_reg_address), 64'(a));
        checkOutput("wr_data", 64'(bus.o_reg_wr_data), 64'(d));
        checkOutput("wr_strb", 64'(bus.o_reg_wr_strb), 64'(s));
        while (bus.o_reg_wr_req && k < 40) begin
            k++;
            bus.i_reg_wr_ack_stb   = (k == ack_at);
            bus.i_reg_invalid_addr = (k == ack_at) ? inv : 1'($urandom_range(0, 1));
            bus.i_reg_rd_ack_stb   = (k == ack_at) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        bus.i_reg_wr_ack_stb   = 1'b0;
        bus.i_reg_rd_ack_stb   = 1'b0;
        bus.i_reg_invalid_addr = 1'b0;
        checkOutput("wr_req_cycles", 64'(k), 64'(expected_req_cycles(ack_at)));
        checkOutput("bvalid", 64'(bus.o_bvalid), 64'(1));
        checkOutput("bresp", 64'(bus.o_bresp), 64'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            bus.i_awvalid = 1'($urandom_range(0, 1));
            bus.i_wvalid  = 1'($urandom_range(0, 1));
            bus.i_arvalid = 1'($urandom_range(0, 1));
            #1;
            checkOutput("bp_readies", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'(0));
            checkOutput("bp_bvalid", 64'(bus.o_bvalid), 64'(1));
            checkOutput("bp_bresp", 64'(bus.o_bresp), 64'(exp_resp));
            tick();
        end
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        bus.i_arvalid = 1'b0;
        bus.i_bready  = 1'b1;
        tick();
        bus.i_bready = 1'b0;
        checkOutput("bvalid_clear", 64'(bus.o_bvalid), 64'(0));
        model_prio_read = 1'b1;
    endtask

    task automatic read_txn(input logic [15:0] a, input logic [31:0] d, input int ack_at,
                            input bit inv, input int r_dly);
        int k = 0;
        logic [1:0]  exp_resp = expected_resp(ack_at, inv);
        logic [31:0] exp_data = (ack_at > TIMEOUT) ? 32'h0 : d;
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        bus.i_araddr  = a;
        bus.i_arvalid = 1'b1;
        #1;
        checkOutput("arready", 64'(bus.o_arready), 64'(1));
        tick();
        bus.i_arvalid = 1'b0;
        checkOutput("rd_req", 64'(bus.o_reg_rd_req), 64'(1));
        checkOutput("rd_addr", 64'(bus.o_reg_address), 64'(a));
        checkOutput("rdata_hold", 64'(bus.o_rdata), 64'(model_rdata));
        while (bus.o_reg_rd_req && k < 40) begin
            k++;
            bus.i_reg_rd_ack_stb   = (k == ack_at);
            bus.i_reg_rd_data      = (k == ack_at) ? d : 32'($urandom);
            bus.i_reg_invalid_addr = (k == ack_at) ? inv : 1'($urandom_range(0, 1));
            bus.i_reg_wr_ack_stb   = (k == ack_at) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        bus.i_reg_rd_ack_stb   = 1'b0;
        bus.i_reg_wr_ack_stb   = 1'b0;
        bus.i_reg_invalid_addr = 1'b0;
        checkOutput("rd_req_cycles", 64'(k), 64'(expected_req_cycles(ack_at)));
        checkOutput("rvalid", 64'(bus.o_rvalid), 64'(1));
        checkOutput("rresp", 64'(bus.o_rresp), 64'(exp_resp));
        checkOutput("rdata", 64'(bus.o_rdata), 64'(exp_data));
        for (int i = 0; i < r_dly; i++) begin
            bus.i_awvalid = 1'($urandom_range(0, 1));
            bus.i_wvalid  = 1'($urandom_range(0, 1));
            bus.i_arvalid = 1'($urandom_range(0, 1));
            #1;
            checkOutput("bp_readies", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'(0));
            checkOutput("bp_rvalid", 64'(bus.o_rvalid), 64'(1));
            checkOutput("bp_rdata", 64'(bus.o_rdata), 64'(exp_data));
            tick();
        end
        bus.i_awvalid = 1'b0;
        bus.i_wvalid  = 1'b0;
        bus.i_arvalid = 1'b0;
        bus.i_rready  = 1'b1;
        tick();
        bus.i_rready = 1'b0;
        checkOutput("rvalid_clear", 64'(bus.o_rvalid), 64'(0));
        model_rdata     = exp_data;
        model_prio_read = 1'b0;
    endtask

    // Raise all three request valids together and check who the arbiter favours.
    task automatic check_grant();
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        bus.i_arvalid = 1'b1;
        #1;
        checkOutput("grant", 64'({bus.o_awready, bus.o_wready, bus.o_arready}),
                    model_prio_read ? 64'(3'b001) : 64'(3'b110));
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 1) == 1) begin
            write_txn(16'($urandom), 32'($urandom), 4'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
        end else begin
            read_txn(16'($urandom), 32'($urandom), int'($urandom_range(1, 10)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_prio_read = 1'b0;
        model_rdata     = 32'h0;

        #2;
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        bus.i_arvalid = 1'b1;
        #1;
        checkOutput("reset_readies", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'(0));
        checkOutput("reset_valids", 64'({bus.o_bvalid, bus.o_rvalid, bus.o_reg_wr_req, bus.o_reg_rd_req}), 64'(0));
        checkOutput("reset_rdata", 64'(bus.o_rdata), 64'(0));
        checkOutput("reset_addr", 64'(bus.o_reg_address), 64'(0));
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // W leads AW by three cycles, ack on the third request cycle.
        write_txn(16'h0010, 32'hA5A5A5A5, 4'b0011, 3, 0, 3, 1'b0, 0);
        read_txn(16'h00FC, 32'h12345678, 2, 1'b1, 1);

        for (int i = 0; i < 8; i++) begin
            check_grant();
            if (model_prio_read) begin
                read_txn(16'($urandom), 32'($urandom), int'($urandom_range(1, 4)), 1'b0, 0);
            end else begin
                write_txn(16'($urandom), 32'($urandom), 4'($urandom), 0, 0,
                          int'($urandom_range(1, 4)), 1'b0, 0);
            end
        end

        read_txn(16'h0020, 32'hCAFEF00D, TIMEOUT + 1, 1'b0, 0);
        read_txn(16'h0024, 32'hDEADBEEF, TIMEOUT, 1'b0, 0);
        write_txn(16'h0028, 32'h01020304, 4'b1111, 0, 1, TIMEOUT + 4, 1'b1, 5);
        read_txn(16'h002C, 32'h55AA55AA, 1, 1'b0, 5);

        for (int i = 0; i < 16; i++) begin
            applyStimulus();
        end

        // Reset in the middle of a read that is still waiting for its ack.
        bus.i_araddr  = 16'h0040;
        bus.i_arvalid = 1'b1;
        tick();
        bus.i_arvalid = 1'b0;
        tick();
        tick();
        checkOutput("pre_rst_rd_req", 64'(bus.o_reg_rd_req), 64'(1));
        bus.i_awvalid = 1'b1;
        bus.i_wvalid  = 1'b1;
        bus.i_arvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_req", 64'(bus.o_reg_rd_req), 64'(0));
        checkOutput("rst_readies", 64'({bus.o_awready, bus.o_wready, bus.o_arready}), 64'(0));
        tick();
        tick();
        idle_inputs();
        rst_n = 1'b1;
        model_prio_read = 1'b0;
        model_rdata     = 32'h0;
        bus.i_rready    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checkOutput("post_rst_quiet", 64'({bus.o_rvalid, bus.o_bvalid, bus.o_reg_rd_req}), 64'(0));
            tick();
        end
        bus.i_rready = 1'b0;
        check_grant();
        write_txn(16'h0044, 32'h0BADF00D, 4'b0101, 0, 0, 2, 1'b0, 0);
        check_grant();
        read_txn(16'h0048, 32'h87654321, 3, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
